mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  EX/MEM pipeline register plus data-memory access unit of the 5-stage RV32I core.
//  Captures EX results each cycle and drives a req/ack data-memory bus for loads and stores.
//  Also generates byte enables, load sign/zero extension, a pipeline stall and a bus-timeout error.
//  Feeds ALUResult_mem/rdAddr_mem/RegWrite_mem back to EX forwarding; feeds the MEM/WB register.
// PARAMETERS
//  XLEN     32  datapath width
//  TIMEOUT  16  max cycles waiting for dmem_ack before error; range 1..255
// PORTS
//  clk              in   1     core clock, rising edge
//  reset            in   1     synchronous, active-high
//  ALUResult_ex     in   32    EX ALU result (address for ld/st)
//  MemWriteData_ex  in   32    forwarded rs2 data for stores
//  rdAddr_ex        in   5     destination register
//  RegWrite_ex      in   1     register write enable
//  MemRead_ex       in   1     load
//  MemWrite_ex      in   1     store
//  MemtoReg_ex      in   1     WB selects load data
//  funct3_ex        in   3     access size/sign (RV32I encoding)
//  dmem_rdata       in   32    memory read data, valid with dmem_ack
//  dmem_ack         in   1     memory completes access this cycle
//  ALUResult_mem    out  32    registered ALU result
//  rdAddr_mem       out  5     registered rd
//  RegWrite_mem     out  1     registered write enable (forced 0 on error)
//  MemtoReg_mem     out  1     registered
//  MemDout_mem      out  32    aligned/extended load data, valid in ack cycle
//  dmem_req         out  1     access request
//  dmem_we          out  1     1=store
//  dmem_addr        out  32    word-aligned address {ALUResult_mem[31:2],2'b00}
//  dmem_wdata       out  32    store data replicated into the byte/half lanes
//  dmem_be          out  4     byte enables
//  stall_mem        out  1     freeze PC, IF/ID, ID/EX and this register
//  mem_err          out  1     1-cycle pulse: misaligned access or timeout
// BEHAVIOUR
//  - Reset: all *_mem registers 0, state IDLE, counter 0; dmem_req, stall_mem, mem_err 0.
//  - Register update: on clk, if !stall_mem load *_ex into *_mem. If stall_mem, hold.
//    Reset overrides stall.
//  - memop = MemRead_mem|MemWrite_mem. Misaligned: half access with addr[0]!=0, or word access with addr[1:0]!=0.
//  - Misaligned op: no dmem_req, no stall; mem_err=1 that cycle; RegWrite_mem output gated to 0.
//  - FSM IDLE: aligned memop -> dmem_req=1 in the same cycle.
//    If dmem_ack, done with no stall (0-wait). Otherwise go to WAIT, stall_mem=1, counter=1.
//  - FSM WAIT: hold dmem_req and all bus outputs stable, stall_mem=1, counter++.
//    On dmem_ack: stall_mem=0 that cycle, go to IDLE.
//    If counter reaches TIMEOUT without ack: mem_err pulse, drop req, release stall, gate RegWrite, go to IDLE.
//  - stall_mem = aligned memop & !dmem_ack & !timeout, combinational. Reset mid-WAIT: return to IDLE, drop req.
//  - ack arriving in IDLE with no req: ignored.
//  - Store be by funct3[1:0] and addr[1:0]: SB 0001<<addr; SH 0011<<addr; SW 1111.
//    wdata: SB {4{b}}, SH {2{h}}.
//  - Load: select lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
//    MemDout_mem = 0 when no load.
//  - Non-memory instructions pass through in 1 cycle with no bus activity.
// STRUCTURE
//  - Shared package: funct3 size codes (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010).
//    Also the FSM state encoding (IDLE, WAIT).
//  - One sub-module: load_align (combinational lane select + extension).
//    Everything else (register, FSM, be/wdata generation) stays in mem_stage.
// TESTING
//  - SW addr 0x100 data 0xDEADBEEF, ack same cycle -> be=1111, wdata=0xDEADBEEF, stall_mem never 1.
//  - LB addr 0x103, rdata 0x80FF_FF7F -> MemDout_mem=0xFFFFFF80; LBU same -> 0x00000080.
//  - LH addr 0x102, ack after 3 cycles -> stall_mem high 3 cycles, req/addr stable, MemDout_mem sign-extended 0x80FF.
//    EX inputs changing during stall are not captured.
//  - LW addr 0x101 -> mem_err pulse, no dmem_req, RegWrite_mem=0, no stall.
//  - No ack for TIMEOUT=16 cycles -> mem_err at cycle 16, stall drops, FSM IDLE; reset asserted mid-WAIT -> req=0 next cycle.
//  - SB addr 0x102 data 0x000000AB -> be=0100, wdata=0xABABABAB; back-to-back load following the store is issued the next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 access codes, FSM states and
// small helpers for access-size decoding.
package mem_stage_pkg;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access size lives in funct3[1:0]; 2'b11 is not a legal RV32I size and is treated as a word
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (funct3[1:0])
      SZ_BYTE: mask = 4'b0001 << addr_lo;
      SZ_HALF: mask = 4'b0011 << addr_lo;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data lane selection and sign/zero extension for the MEM stage.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed byte/half from the word, then extend by funct3
  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{lane_byte[7]}}, lane_byte};
      F3_LBU:  data = {24'd0, lane_byte};
      F3_LH:   data = {{16{lane_half[15]}}, lane_half};
      F3_LHU:  data = {16'd0, lane_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM pipeline register and data-memory access unit (req/ack bus) of the
// RV32I core. Generates byte enables, store lane replication, load alignment,
// the pipeline stall and a 1-cycle error pulse for misalignment or timeout.
//
// state | meaning
// IDLE  | no access outstanding; an aligned memop requests in this cycle
// WAIT  | request outstanding, waiting for dmem_ack; wait_cnt counts cycles
//
// Timeout: the request cycle in IDLE plus WAIT cycles with wait_cnt 1..TIMEOUT-1
// are stalled (TIMEOUT cycles with no ack). The cycle in which wait_cnt equals
// TIMEOUT drops the request, releases the stall and pulses mem_err; an ack in
// that cycle is ignored so that dmem_req never depends on dmem_ack.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ALUResult_ex,
  input  logic [XLEN-1:0] MemWriteData_ex,
  input  logic [4:0]      rdAddr_ex,
  input  logic            RegWrite_ex,
  input  logic            MemRead_ex,
  input  logic            MemWrite_ex,
  input  logic            MemtoReg_ex,
  input  logic [2:0]      funct3_ex,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [XLEN-1:0] ALUResult_mem,
  output logic [4:0]      rdAddr_mem,
  output logic            RegWrite_mem,
  output logic            MemtoReg_mem,
  output logic [XLEN-1:0] MemDout_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  output logic            stall_mem,
  output logic            mem_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [XLEN-1:0] wdata_q;
  logic            regwrite_q;
  logic            memread_q;
  logic            memwrite_q;
  logic [2:0]      funct3_q;

  mem_state_e      state;
  logic [7:0]      wait_cnt;

  logic            memop;
  logic            misaligned;
  logic            aligned_op;
  logic            timeout;
  logic [XLEN-1:0] load_data;

  // EX/MEM register: held while stalled, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResult_mem <= '0;
      wdata_q       <= '0;
      rdAddr_mem    <= '0;
      regwrite_q    <= 1'b0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      MemtoReg_mem  <= 1'b0;
      funct3_q      <= '0;
    end else if (!stall_mem) begin
      ALUResult_mem <= ALUResult_ex;
      wdata_q       <= MemWriteData_ex;
      rdAddr_mem    <= rdAddr_ex;
      regwrite_q    <= RegWrite_ex;
      memread_q     <= MemRead_ex;
      memwrite_q    <= MemWrite_ex;
      MemtoReg_mem  <= MemtoReg_ex;
      funct3_q      <= funct3_ex;
    end
  end

  // Access FSM: track the outstanding request and count wait cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aligned_op && !dmem_ack) begin
            state    <= ST_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_WAIT: begin
          if (timeout || dmem_ack) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Access classification, bus handshake, stall and error generation
  always_comb begin
    memop      = memread_q | memwrite_q;
    misaligned = memop & is_misaligned(funct3_q, ALUResult_mem[1:0]);
    aligned_op = memop & ~misaligned;
    timeout    = (state == ST_WAIT) && (wait_cnt == TIMEOUT_CNT);
    dmem_req   = aligned_op & ~timeout;
    stall_mem  = aligned_op & ~dmem_ack & ~timeout;
    mem_err    = misaligned | timeout;
    RegWrite_mem = regwrite_q & ~mem_err;
  end

  // Bus address, write enable, byte enables and lane-replicated store data
  always_comb begin
    dmem_addr = {ALUResult_mem[XLEN-1:2], 2'b00};
    dmem_we   = dmem_req & memwrite_q;
    dmem_be   = dmem_req ? byte_mask(funct3_q, ALUResult_mem[1:0]) : 4'b0000;
    case (funct3_q[1:0])
      SZ_BYTE: dmem_wdata = {4{wdata_q[7:0]}};
      SZ_HALF: dmem_wdata = {2{wdata_q[15:0]}};
      default: dmem_wdata = wdata_q;
    endcase
  end

  load_align u_load_align (
    .rdata   (dmem_rdata),
    .addr_lo (ALUResult_mem[1:0]),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  // Load result is only presented in the cycle the memory acknowledges a load
  always_comb begin
    MemDout_mem = (dmem_req && memread_q && dmem_ack) ? load_data : '0;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed spec scenarios plus randomized
// loads/stores checked against a size/offset arithmetic reference model.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult_ex, MemWriteData_ex, dmem_rdata;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, dmem_ack;
  logic [2:0]  funct3_ex;
  logic [31:0] ALUResult_mem, MemDout_mem, dmem_addr, dmem_wdata;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem, MemtoReg_mem, dmem_req, dmem_we, stall_mem, mem_err;
  logic [3:0]  dmem_be;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ALUResult_ex(ALUResult_ex), .MemWriteData_ex(MemWriteData_ex),
    .rdAddr_ex(rdAddr_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
    .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex), .funct3_ex(funct3_ex),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .ALUResult_mem(ALUResult_mem), .rdAddr_mem(rdAddr_mem), .RegWrite_mem(RegWrite_mem),
    .MemtoReg_mem(MemtoReg_mem), .MemDout_mem(MemDout_mem), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .stall_mem(stall_mem), .mem_err(mem_err)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = nbytes(f3);
    return 4'(((1 << n) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (nbytes(f3))
      1:       return 32'(d & 32'hFF) * 32'h0101_0101;
      2:       return 32'(d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    longint v;
    int n, sh;
    n  = nbytes(f3);
    sh = 8 * int'(addr[1:0]);
    v  = longint'(rdata >> sh) & ((longint'(1) << (8 * n)) - 1);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] alu, wd, input logic [4:0] rd,
                          input logic rw, mr, mw, m2r, input logic [2:0] f3);
    ALUResult_ex = alu; MemWriteData_ex = wd; rdAddr_ex = rd; RegWrite_ex = rw;
    MemRead_ex = mr; MemWrite_ex = mw; MemtoReg_ex = m2r; funct3_ex = f3;
  endtask

  task automatic drive_nop();
    drive_ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // One load or store; ack arrives 'delay' cycles after the request cycle.
  // While stalled, EX inputs carry garbage that must not be captured.
  task automatic run_access(input string tag, input bit is_load, input logic [2:0] f3,
                            input logic [31:0] addr, wd, rdata, input int delay,
                            input logic [4:0] rd, input bit rw, output logic [31:0] dout_seen);
    logic [72:0] got, exp;
    dout_seen = 32'd0;
    drive_ex(addr, wd, rd, rw, is_load, !is_load, is_load, f3);
    dmem_ack = 1'b0;
    step();
    if (model_misaligned(f3, addr)) begin
      drive_nop();
      #2;
      checks++;
      if ({dmem_req, stall_mem, mem_err, RegWrite_mem} !== 4'b0010)
        $display("FAIL %s misaligned req/stall/err/rw got %b want 0010", tag,
                 {dmem_req, stall_mem, mem_err, RegWrite_mem});
      else passed++;
      step();
      return;
    end
    for (int c = 0; c <= delay; c++) begin
      if (c == delay) begin
        dmem_ack = 1'b1; dmem_rdata = rdata; drive_nop();
      end else begin
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        drive_ex($urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 3'($urandom));
      end
      #2;
      got = {dmem_req, dmem_we, stall_mem, mem_err, dmem_addr, ALUResult_mem, rdAddr_mem};
      exp = {1'b1, !is_load, (c != delay), 1'b0, addr & 32'hFFFF_FFFC, addr, rd};
      checks++;
      if (got !== exp) $display("FAIL %s bus cyc%0d got %h want %h", tag, c, got, exp);
      else passed++;
      if (!is_load) begin
        checks++;
        if ({dmem_be, dmem_wdata} !== {model_be(f3, addr), model_wdata(f3, wd)})
          $display("FAIL %s be/wdata got %b/%h want %b/%h", tag, dmem_be, dmem_wdata,
                   model_be(f3, addr), model_wdata(f3, wd));
        else passed++;
      end
      if (c == delay) begin
        dout_seen = MemDout_mem;
        checks++;
        if ({RegWrite_mem, MemDout_mem} !== {rw, is_load ? model_load(f3, addr, rdata) : 32'd0})
          $display("FAIL %s rw/dout got %b/%h want %b/%h", tag, RegWrite_mem, MemDout_mem,
                   rw, is_load ? model_load(f3, addr, rdata) : 32'd0);
        else passed++;
      end
      step();
    end
    dmem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    drive_ex(32'h0000_0100, $urandom, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    step(); step();
    #2;
    checks++;
    if ({ALUResult_mem, rdAddr_mem, RegWrite_mem, MemtoReg_mem, MemDout_mem,
         dmem_req, stall_mem, mem_err} !== 75'd0)
      $display("FAIL reset outputs got alu=%h rd=%0d rw=%b m2r=%b dout=%h req=%b stall=%b err=%b want all 0",
               ALUResult_mem, rdAddr_mem, RegWrite_mem, MemtoReg_mem, MemDout_mem,
               dmem_req, stall_mem, mem_err);
    else passed++;
    reset = 1'b0; drive_nop();
    step();
  endtask

  task automatic test_passthrough();
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw, m2r;
    for (int i = 0; i < 20; i++) begin
      alu = $urandom; rd = 5'($urandom); rw = 1'($urandom); m2r = 1'($urandom);
      drive_ex(alu, $urandom, rd, rw, 1'b0, 1'b0, m2r, 3'($urandom));
      dmem_ack = 1'($urandom);
      step();
      #2;
      checks++;
      if ({ALUResult_mem, rdAddr_mem, RegWrite_mem, MemtoReg_mem, dmem_req, stall_mem,
           mem_err, MemDout_mem} !== {alu, rd, rw, m2r, 3'b000, 32'd0})
        $display("FAIL passthru %0d got alu=%h rd=%0d rw=%b m2r=%b req=%b stall=%b err=%b dout=%h want alu=%h rd=%0d rw=%b m2r=%b rest 0",
                 i, ALUResult_mem, rdAddr_mem, RegWrite_mem, MemtoReg_mem, dmem_req,
                 stall_mem, mem_err, MemDout_mem, alu, rd, rw, m2r);
      else passed++;
    end
    dmem_ack = 1'b0; drive_nop();
    step();
  endtask

  task automatic test_directed();
    logic [31:0] d;
    run_access("sw", 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, 5'd3, 1'b0, d);
    run_access("lb", 1'b1, 3'b000, 32'h103, 32'd0, 32'h80FF_FF7F, 0, 5'd5, 1'b1, d);
    checks++;
    if (d !== 32'hFFFF_FF80) $display("FAIL lb dout got %h want ffffff80", d); else passed++;
    run_access("lbu", 1'b1, 3'b100, 32'h103, 32'd0, 32'h80FF_FF7F, 0, 5'd5, 1'b1, d);
    checks++;
    if (d !== 32'h0000_0080) $display("FAIL lbu dout got %h want 00000080", d); else passed++;
    run_access("lh", 1'b1, 3'b001, 32'h102, 32'd0, 32'h80FF_1234, 3, 5'd6, 1'b1, d);
    checks++;
    if (d !== 32'hFFFF_80FF) $display("FAIL lh dout got %h want ffff80ff", d); else passed++;
    run_access("lw_mis", 1'b1, 3'b010, 32'h101, 32'd0, 32'd0, 0, 5'd7, 1'b1, d);
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    drive_ex(32'h200, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    dmem_ack = 1'b0;
    step();
    drive_nop();
    for (int c = 0; c < TO; c++) begin
      #2;
      checks++;
      if ({dmem_req, stall_mem, mem_err} !== 3'b110)
        $display("FAIL timeout wait cyc%0d req/stall/err got %b want 110", c,
                 {dmem_req, stall_mem, mem_err});
      else passed++;
      step();
    end
    #2;
    checks++;
    if ({dmem_req, stall_mem, mem_err, RegWrite_mem} !== 4'b0010)
      $display("FAIL timeout expiry req/stall/err/rw got %b want 0010",
               {dmem_req, stall_mem, mem_err, RegWrite_mem});
    else passed++;
    step();
    #2;
    checks++;
    if ({dmem_req, mem_err, ALUResult_mem} !== {2'b00, 32'd0})
      $display("FAIL timeout after req/err/alu got %b%b/%h want 00/0", dmem_req, mem_err, ALUResult_mem);
    else passed++;
    run_access("after_to", 1'b1, 3'b010, 32'h204, 32'd0, $urandom, 1, 5'd8, 1'b1, d);

    // reset arriving while a request is outstanding
    drive_ex(32'h300, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    step();
    drive_nop();
    for (int c = 0; c < 4; c++) step();
    reset = 1'b1;
    step();
    #2;
    checks++;
    if ({dmem_req, stall_mem, ALUResult_mem} !== {2'b00, 32'd0})
      $display("FAIL reset_mid_wait req/stall/alu got %b%b/%h want 00/0", dmem_req, stall_mem, ALUResult_mem);
    else passed++;
    reset = 1'b0;
    step();
    run_access("after_rst", 1'b1, 3'b101, 32'h302, 32'd0, $urandom, 0, 5'd2, 1'b1, d);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    drive_ex(32'h102, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    dmem_ack = 1'b0;
    step();
    drive_ex(32'h104, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    dmem_ack = 1'b1;
    #2;
    checks++;
    if ({dmem_req, dmem_we, stall_mem, dmem_be, dmem_wdata} !== {3'b110, 4'b0100, 32'hABAB_ABAB})
      $display("FAIL b2b sb req/we/stall/be/wdata got %b%b%b/%b/%h want 110/0100/abababab",
               dmem_req, dmem_we, stall_mem, dmem_be, dmem_wdata);
    else passed++;
    step();
    r = $urandom;
    dmem_rdata = r; dmem_ack = 1'b1; drive_nop();
    #2;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, RegWrite_mem, MemDout_mem} !== {2'b10, 32'h104, 1'b1, r})
      $display("FAIL b2b lw req/we/addr/rw/dout got %b%b/%h/%b/%h want 10/00000104/1/%h",
               dmem_req, dmem_we, dmem_addr, RegWrite_mem, MemDout_mem, r);
    else passed++;
    step();
    dmem_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0]  load_f3 [5];
    logic [2:0]  f3;
    logic [31:0] addr, d;
    bit          is_load;
    load_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 40; i++) begin
      is_load = 1'($urandom);
      f3 = is_load ? load_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % nbytes(f3));
      run_access($sformatf("rnd%0d", i), is_load, f3, addr, $urandom, $urandom,
                 $urandom_range(0, 4), 5'($urandom), 1'($urandom), d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    drive_nop();
    test_reset();
    test_passthrough();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
